// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: state type, inverse S-box,
// GF(2^8) helpers and the InvShiftRows / InvMixColumns transforms.
package aes_pkg;

    localparam int NB = 4;

    // Byte 0 sits in [127:120]; column c holds bytes 4c..4c+3.
    typedef logic [0:15][7:0] state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; constant b folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Row r of the result takes column (c - r) mod 4 of the input.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c+r] = s[4*((c - r + 4) % 4) + r];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            o[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                     ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                     ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                     ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                     ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte.
// Ports: value (8-bit byte in), result (8-bit substituted byte).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    assign result = INV_SBOX[value];

endmodule

// File: rtl/aes_inv_round_core.sv
// Iterative AES inverse cipher, one inverse round per clock.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_block
// ciphertext handshake; rk_idx/rk_data round-key fetch (combinational
// key store); out_valid/out_ready/out_block plaintext handshake; busy.
// Optional: define AES_INV_CORE_ABORT_EN to add the abort input, which
// drops the in-flight block and returns to IDLE.
module aes_inv_round_core
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    output logic [IDX_W-1:0] rk_idx,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic             busy
`ifdef AES_INV_CORE_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] RK_LAST  = IDX_W'(NR);
    localparam logic [IDX_W-1:0] RK_FIRST = IDX_W'(NR - 1);

    logic [1:0]       fsm;
    state_t           st;
    logic [IDX_W-1:0] rnd;

    state_t shifted;
    state_t subbed;
    state_t t;
    state_t mixed;
    logic   kill;

`ifdef AES_INV_CORE_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    assign shifted = inv_shift_rows(st);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .value  (shifted[i]),
            .result (subbed[i])
        );
    end

    // Round output before InvMixColumns; the last round skips it.
    assign t     = subbed ^ rk_data;
    assign mixed = inv_mix_columns(t);

    // Abort also blocks acceptance in IDLE.
    assign in_ready = (fsm == S_IDLE) && !kill;
    assign rk_idx   = (fsm == S_IDLE) ? RK_LAST : rnd;
    assign busy     = (fsm != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            st        <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st  <= in_block ^ rk_data;
                        rnd <= RK_FIRST;
                        fsm <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (kill) begin
                        fsm       <= S_IDLE;
                        out_valid <= 1'b0;
                        st        <= '0;
                        rnd       <= '0;
                    end else if (rnd != '0) begin
                        st  <= mixed;
                        rnd <= rnd - 1'b1;
                    end else begin
                        out_block <= t;
                        out_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (kill) begin
                        fsm       <= S_IDLE;
                        out_valid <= 1'b0;
                        st        <= '0;
                        rnd       <= '0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_core.sv
// Bench for aes_inv_round_core: forward-cipher reference model, key store,
// per-cycle output compare and FIPS-197 literal vectors.
module tb_aes_inv_round_core;

    localparam int NR = 10;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;
    logic         abort = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk_drv [11] = '{default: '0};
    logic [127:0] rk_run [11] = '{default: '0};
    logic [127:0] drv_pt = '0;

    // Model: phase 0 idle, k = k-th RUN cycle, NR+1 waiting for out_ready.
    int           m_phase = 0;
    logic         m_outv = 1'b0;
    logic [127:0] m_out = '0;
    logic [127:0] m_exp = '0;
    int           m_nacc = 0;
    int           acc_cyc = 0;

    aes_inv_round_core #(.NR(NR), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
`ifdef AES_INV_CORE_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(logic [7:0] b, int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] rkey(logic [127:0] key, int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Forward cipher: the bench checks that the DUT inverts it.
    function automatic logic [127:0] encrypt(logic [127:0] key,
                                             logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ rkey(key, 0);
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    u[4*c+q] = s[4*((c + q) % 4) + q];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = u[4*c]; a1 = u[4*c+1];
                    a2 = u[4*c+2]; a3 = u[4*c+3];
                    u[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
                    u[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
                    u[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
                    u[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
            v = v ^ rkey(key, r);
        end
        return v;
    endfunction

    // Key store: serves the incoming block's key until it is accepted.
    always_comb begin
        rk_data = '0;
        if (rk_idx <= 4'd10)
            rk_data = (m_phase == 0) ? rk_drv[rk_idx] : rk_run[rk_idx];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_outv  <= 1'b0;
            m_out   <= '0;
        end else if (abort && m_phase != 0) begin
            m_phase <= 0;
            m_outv  <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid && !abort) begin
                m_phase <= 1;
                m_exp   <= drv_pt;
                rk_run  <= rk_drv;
                acc_cyc <= cyc;
                m_nacc  <= m_nacc + 1;
            end
        end else if (m_phase < NR) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == NR) begin
            m_phase <= NR + 1;
            m_outv  <= 1'b1;
            m_out   <= m_exp;
        end else if (out_ready) begin
            m_phase <= 0;
            m_outv  <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event within 100 cycles, expected one", nm);
    endtask

    // Per-cycle compare against the model.
    initial begin
        logic ov_prev;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("in_ready", 128'(in_ready),
                128'(m_phase == 0 && !abort));
            chk("busy", 128'(busy), 128'(m_phase != 0));
            chk("out_valid", 128'(out_valid), 128'(m_outv));
            chk("out_block", out_block, m_out);
            if (m_phase <= NR)
                chk("rk_idx", 128'(rk_idx),
                    128'(m_phase == 0 ? NR : NR - m_phase));
            if (out_valid && !ov_prev)
                chk("latency", 128'(cyc - acc_cyc), 128'(NR + 1));
            ov_prev = out_valid;
        end
    end

    task automatic load(input logic [127:0] key, input logic [127:0] pt);
        for (int r = 0; r <= 10; r++) rk_drv[r] = rkey(key, r);
        drv_pt   = pt;
        in_block = encrypt(key, pt);
    endtask

    task automatic wait_acc();
        int  n0;
        bit  ok;
        n0 = m_nacc;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #1;
            ok = (m_nacc != n0);
        end
        if (!ok) timeout("accept_timeout");
    endtask

    task automatic wait_outv();
        bit ok;
        ok = m_outv;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #1;
            ok = m_outv;
        end
        if (!ok) timeout("out_valid_timeout");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = (m_phase == 0);
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #1;
            ok = (m_phase == 0);
        end
        if (!ok) timeout("idle_timeout");
    endtask

    task automatic run_vec(input logic [127:0] key, input logic [127:0] pt,
                           input int low, input bit use_lit,
                           input logic [127:0] lit);
        load(key, pt);
        out_ready = (low == 0);
        in_valid  = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        wait_outv();
        if (use_lit) chk("out_literal", out_block, lit);
        repeat (low) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        int a1;
        logic [127:0] k, p;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3)
                    ^ rl(inv, 4) ^ 8'h63;
        end
        chk("model_c1", encrypt(K1, P1), C1);
        chk("model_c2", encrypt(K2, P2), C2);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_rk_idx", 128'(rk_idx), 128'(10));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_block", out_block, 128'h0);
        rst = 1'b0;

        // FIPS-197 C.1, then App. B with a stalled consumer.
        run_vec(K1, P1, 0, 1'b1, P1);
        run_vec(K2, P2, 5, 1'b1, P2);
        chk("idle_after_hs", 128'(busy), 128'(0));

        // Back-to-back with in_valid held high.
        load(K1, P1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        wait_acc();
        a1 = acc_cyc;
        load(K2, P2);
        wait_acc();
        chk("b2b_gap", 128'(acc_cyc - a1), 128'(NR + 2));
        in_valid = 1'b0;
        wait_outv();
        chk("b2b_second", out_block, P2);
        wait_idle();

        // Async reset in RUN cycle 4.
        load(K1, P1);
        in_valid = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_rk_idx", 128'(rk_idx), 128'(10));
        chk("arst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(K1, P1, 0, 1'b1, P1);

`ifdef AES_INV_CORE_ABORT_EN
        // Abort in RUN cycle 6.
        load(K2, P2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", 128'(busy), 128'(0));
        repeat (15) @(posedge clk);
        #1;
        run_vec(K1, P1, 0, 1'b1, P1);
`endif

        for (int n = 0; n < 8; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_vec(k, p, int'($urandom_range(0, 3)), 1'b1, p);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
